// File: rtl/subt_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : subt_div_ctrl
// Brief    : Unsigned divider sequencer using one external subtractor
//            (repeated subtraction). Optional abort via SUBT_DIV_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module subt_div_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
`ifdef SUBT_DIV_ABORT_EN
    input  logic         abort,
`endif
    output logic         ready,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic [W-1:0] sub_a,
    output logic [W-1:0] sub_b,
    input  logic [W-1:0] sub_d,
    input  logic         sub_bout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   div_q, div_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   quotient_q, quotient_d;
    logic [W-1:0]   remainder_q, remainder_d;
    logic           dbz_q, dbz_d;
    logic           abort_req;

`ifdef SUBT_DIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        div_d       = div_q;
        q_d         = q_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        rem_d   = dividend;
                        div_d   = divisor;
                        q_d     = '0;
                        dbz_d   = 1'b0;
                        state_d = S_SUB;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_SUB: begin
                // Abort wins over completion and leaves published results untouched
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (!sub_bout) begin
                    rem_d = sub_d;
                    q_d   = q_q + {{(W-1){1'b0}}, 1'b1};
                end else begin
                    quotient_d  = q_q;
                    remainder_d = rem_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            div_q       <= '0;
            q_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            q_q         <= q_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign sub_a       = rem_q;
    assign sub_b       = div_q;

endmodule
`default_nettype wire

// File: tb/tb_subt_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_subt_div_ctrl
// Brief    : Self-checking bench for subt_div_ctrl (W=4), directed + random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subt_div_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [W-1:0] sub_a;
    logic [W-1:0] sub_b;
    logic [W-1:0] sub_d;
    logic         sub_bout;
`ifdef SUBT_DIV_ABORT_EN
    logic         abort;
`endif

    int n_checks;
    int n_errors;

    subt_div_ctrl #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SUBT_DIV_ABORT_EN
        .abort       (abort),
`endif
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_d       (sub_d),
        .sub_bout    (sub_bout)
    );

    // External subtractor
    assign sub_d    = sub_a - sub_b;
    assign sub_bout = (sub_a < sub_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One division; inject_at>0 drives a 4/2 start pulse at that busy cycle.
    task automatic run_div(input int a, input int b, input int inject_at);
        int exp_q, exp_r, exp_lat, cycles;
        if (b == 0) begin
            exp_q = 15; exp_r = a; exp_lat = 1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_lat = exp_q + 2;
        end
        @(negedge clk);
        check_eq("ready_idle", ready, 1);
        start = 1'b1; dividend = W'(a); divisor = W'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dividend = '0; divisor = '0;
        cycles = 1;
        while (!done && cycles < 40) begin
            check_eq("ready_busy", ready, 0);
            if (b != 0 && cycles <= exp_q + 1) begin
                check_eq("sub_a", sub_a, a - (cycles - 1) * b);
                check_eq("sub_b", sub_b, b);
            end
            if (inject_at > 0 && cycles == inject_at) begin
                start = 1'b1; dividend = 4'd4; divisor = 4'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_eq("done_seen", done, 1);
        check_eq("latency", cycles, exp_lat);
        check_eq("ready_done", ready, 0);
        check_eq("quotient", quotient, exp_q);
        check_eq("remainder", remainder, exp_r);
        check_eq("dbz", div_by_zero, (b == 0) ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("done_pulse", done, 0);
            check_eq("ready_after", ready, 1);
            check_eq("q_hold", quotient, exp_q);
            check_eq("r_hold", remainder, exp_r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef SUBT_DIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("rst_ready", ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_q", quotient, 0);
        check_eq("rst_r", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        check_eq("rst_sub_a", sub_a, 0);
        check_eq("rst_sub_b", sub_b, 0);
        rst_n = 1'b1;

        run_div(13, 6, 0);
        run_div(10, 5, 0);
        run_div(3, 5, 0);
        run_div(9, 0, 0);
        run_div(8, 2, 0);
        run_div(15, 1, 5);

        // Async reset in the middle of 12/3
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_q", quotient, 0);
        check_eq("arst_r", remainder, 0);
        check_eq("arst_ready", ready, 1);
        check_eq("arst_done", done, 0);
        check_eq("arst_sub_a", sub_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("arst_nodone", done, 0);
        end
        run_div(7, 2, 0);

`ifdef SUBT_DIV_ABORT_EN
        run_div(6, 3, 0);
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_ready", ready, 1);
        check_eq("abort_done", done, 0);
        check_eq("abort_q", quotient, 2);
        check_eq("abort_r", remainder, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_eq("abort_nodone", done, 0);
        end
`endif

        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            run_div(a, b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
